id_ex_fwd_stage: RTL and testbench

- ID/EX pipeline register for the pipelined RV32I core.
- Detects load-use hazards and inserts exactly one bubble per hazard.
- Pre-computes the 2-bit operand-select codes consumed by the execute-stage three-input operand muxes (00 = register file, 01 = WB result, 10 = MEM ALU result). The selects are registered, so execute sees them with zero combinational delay.

---
 rtl/id_ex_fwd_stage_pkg.sv | 15 +
 rtl/id_ex_fwd_stage_fwd_sel_gen.sv | 31 +++
 rtl/id_ex_fwd_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared definitions for the ID/EX stage: operand-select codes, core widths
// and the control-bundle value carried by a bubble.
package id_ex_fwd_stage_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_gen.sv
// Operand-select generator for one source register. The select is chosen at
// ID for the stage each producer will occupy once this instruction reaches EX.
module fwd_sel_gen
  import id_ex_fwd_stage_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_src,
  input  logic                 i_uses,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_reg_write,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_mem_reg_write,
  input  logic [REG_IDX_W-1:0] i_mem_rd,
  output logic [1:0]           o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_ex_valid & i_ex_reg_write & (i_ex_rd != '0) & (i_ex_rd == i_src);
  assign w_mem_hit = i_mem_reg_write & (i_mem_rd != '0) & (i_mem_rd == i_src);

  // The EX producer is the younger one, so it wins over MEM.
  always_comb begin
    o_sel = FWD_RF;
    if (i_uses) begin
      if (w_ex_hit)       o_sel = FWD_MEM;
      else if (w_mem_hit) o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use stall, WB write-through and
// registered execute-stage operand selects.
module id_ex_fwd_stage
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int XLEN   = id_ex_fwd_stage_pkg::XLEN,
  parameter int CTRL_W = id_ex_fwd_stage_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic                 mem_reg_write,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_reg_write,
  input  logic [XLEN-1:0]      wb_wdata,
  input  logic                 hold,
  input  logic                 ex_flush,
  output logic                 stall_o,
  output logic                 ex_valid,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [XLEN-1:0]      ex_pc,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [1:0]           ex_fwd_a_sel,
  output logic [1:0]           ex_fwd_b_sel,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic                 r_valid, r_reg_write, r_mem_read, r_mem_write;
  logic [REG_IDX_W-1:0] r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]      r_rs1_data, r_rs2_data, r_imm, r_pc;
  logic [CTRL_W-1:0]    r_ctrl;
  logic [1:0]           r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0]     r_bubble_cnt;

  logic            w_lu, w_capture, w_lu_bubble;
  logic [1:0]      w_fwd_a, w_fwd_b;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;

  assign w_lu = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                ((id_uses_rs1 & (id_rs1 == r_rd)) | (id_uses_rs2 & (id_rs2 == r_rd)));

  assign stall_o     = w_lu & ~hold & ~ex_flush;
  assign w_lu_bubble = w_lu & ~ex_flush;
  assign w_capture   = id_valid & ~w_lu & ~ex_flush;

  // The register file reads before it writes, so a same-cycle WB value is taken here.
  assign w_rs1_data = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs1) ? wb_wdata : id_rs1_data;
  assign w_rs2_data = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs2) ? wb_wdata : id_rs2_data;

  fwd_sel_gen u_fwd_a (
    .i_src          (id_rs1),
    .i_uses         (id_uses_rs1),
    .i_ex_valid     (r_valid),
    .i_ex_reg_write (r_reg_write),
    .i_ex_rd        (r_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_mem_rd       (mem_rd),
    .o_sel          (w_fwd_a)
  );

  fwd_sel_gen u_fwd_b (
    .i_src          (id_rs2),
    .i_uses         (id_uses_rs2),
    .i_ex_valid     (r_valid),
    .i_ex_reg_write (r_reg_write),
    .i_ex_rd        (r_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_mem_rd       (mem_rd),
    .o_sel          (w_fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_ctrl       <= CTRL_W'(CTRL_BUBBLE);
      r_fwd_a      <= FWD_RF;
      r_fwd_b      <= FWD_RF;
      r_bubble_cnt <= '0;
    end else if (!hold) begin
      if (w_capture) begin
        r_valid     <= 1'b1;
        r_reg_write <= id_reg_write;
        r_mem_read  <= id_mem_read;
        r_mem_write <= id_mem_write;
        r_rs1       <= id_rs1;
        r_rs2       <= id_rs2;
        r_rd        <= id_rd;
        r_rs1_data  <= w_rs1_data;
        r_rs2_data  <= w_rs2_data;
        r_imm       <= id_imm;
        r_pc        <= id_pc;
        r_ctrl      <= id_ctrl;
        r_fwd_a     <= w_fwd_a;
        r_fwd_b     <= w_fwd_b;
      end else begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_rs1       <= '0;
        r_rs2       <= '0;
        r_rd        <= '0;
        r_rs1_data  <= '0;
        r_rs2_data  <= '0;
        r_imm       <= '0;
        r_pc        <= '0;
        r_ctrl      <= CTRL_W'(CTRL_BUBBLE);
        r_fwd_a     <= FWD_RF;
        r_fwd_b     <= FWD_RF;
      end
      if (w_lu_bubble && r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_mem_write = r_mem_write;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_rs1_data  = r_rs1_data;
  assign ex_rs2_data  = r_rs2_data;
  assign ex_imm       = r_imm;
  assign ex_pc        = r_pc;
  assign ex_ctrl      = r_ctrl;
  assign ex_fwd_a_sel = r_fwd_a;
  assign ex_fwd_b_sel = r_fwd_b;
  assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: forwarding selects, load-use bubbles,
// write-through, hold/flush priority and asynchronous reset.
module tb_id_ex_fwd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [7:0]  id_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] wb_wdata;
  logic        hold, ex_flush;
  logic        stall_o;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [7:0]  ex_ctrl;
  logic [1:0]  ex_fwd_a_sel, ex_fwd_b_sel;
  logic [15:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_wdata(wb_wdata),
    .hold(hold), .ex_flush(ex_flush), .stall_o(stall_o),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
    .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
    .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic [31:0] pc);
    id_valid = 1'b1;
    id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    id_rs1_data = 32'h1000 + 32'(rs1);
    id_rs2_data = 32'h2000 + 32'(rs2);
    id_pc = pc; id_imm = pc + 32'h4; id_ctrl = pc[7:0] ^ 8'h5A;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_pc = 0; id_ctrl = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; mem_rd = 0; mem_reg_write = 0; wb_rd = 0;
    wb_reg_write = 0; wb_wdata = 0; hold = 0; ex_flush = 0;
    step(); step();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);

    // add x5, x1, x2
    rst_n = 1'b1;
    set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 32'h100);
    step();
    check("add_ex_valid", 32'(ex_valid), 32'd1);
    check("add_ex_rd", 32'(ex_rd), 32'd5);
    check("add_ex_pc", ex_pc, 32'h100);
    check("add_ex_imm", ex_imm, 32'h104);
    check("add_ex_ctrl", 32'(ex_ctrl), 32'h5A);
    check("add_ex_rs1_data", ex_rs1_data, 32'h1001);

    // RAW on the ALU producer in EX
    set_id(5'd5, 1, 5'd3, 1, 5'd8, 1, 0, 32'h104);
    #1 check("raw_stall", 32'(stall_o), 32'd0);
    step();
    check("raw_fwd_a", 32'(ex_fwd_a_sel), 32'd2);
    check("raw_fwd_b", 32'(ex_fwd_b_sel), 32'd0);

    // lw x6
    set_id(5'd1, 1, 5'd2, 0, 5'd6, 1, 1, 32'h108);
    step();
    check("lw_ex_mem_read", 32'(ex_mem_read), 32'd1);

    // load-use on rs2
    set_id(5'd1, 1, 5'd6, 1, 5'd9, 1, 0, 32'h10C);
    #1 check("lu_stall", 32'(stall_o), 32'd1);
    step();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_pc", ex_pc, 32'd0);
    check("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    mem_rd = 5'd6; mem_reg_write = 1'b1;
    #1 check("lu_stall_cleared", 32'(stall_o), 32'd0);
    step();
    check("lu_retry_valid", 32'(ex_valid), 32'd1);
    check("lu_retry_fwd_b", 32'(ex_fwd_b_sel), 32'd1);
    check("lu_retry_fwd_a", 32'(ex_fwd_a_sel), 32'd0);
    check("lu_retry_cnt", 32'(bubble_cnt), 32'd1);

    // load targeting x0, then x0 source and an unused matching rs2
    mem_reg_write = 1'b0;
    set_id(5'd1, 1, 5'd2, 1, 5'd0, 1, 1, 32'h110);
    step();
    mem_rd = 5'd4; mem_reg_write = 1'b1;
    set_id(5'd0, 1, 5'd4, 0, 5'd10, 1, 0, 32'h114);
    #1 check("x0_stall", 32'(stall_o), 32'd0);
    step();
    check("x0_fwd_a", 32'(ex_fwd_a_sel), 32'd0);
    check("unused_fwd_b", 32'(ex_fwd_b_sel), 32'd0);

    // WB write-through
    mem_reg_write = 1'b0;
    set_id(5'd7, 1, 5'd3, 1, 5'd11, 1, 0, 32'h1C0);
    id_rs1_data = 32'h0;
    wb_rd = 5'd7; wb_reg_write = 1'b1; wb_wdata = 32'hDEADBEEF;
    step();
    check("wt_rs1_data", ex_rs1_data, 32'hDEADBEEF);
    check("wt_rs2_data", ex_rs2_data, 32'h2003);
    check("wt_fwd_a", 32'(ex_fwd_a_sel), 32'd0);
    wb_reg_write = 1'b0;

    // hold beats flush for three cycles
    hold = 1'b1; ex_flush = 1'b1;
    set_id(5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_ex_pc", ex_pc, 32'h1C0);
      check("hold_ex_valid", 32'(ex_valid), 32'd1);
    end
    hold = 1'b0;
    step();
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_ex_pc", ex_pc, 32'd0);
    ex_flush = 1'b0;

    // load hazard under hold is not counted
    set_id(5'd1, 1, 5'd2, 1, 5'd12, 1, 1, 32'h204);
    step();
    set_id(5'd12, 1, 5'd2, 1, 5'd13, 1, 0, 32'h208);
    hold = 1'b1;
    #1 check("hold_lu_stall", 32'(stall_o), 32'd0);
    step(); step();
    check("hold_lu_cnt", 32'(bubble_cnt), 32'd1);
    check("hold_lu_ex_rd", 32'(ex_rd), 32'd12);
    hold = 1'b0;
    #1 check("unhold_lu_stall", 32'(stall_o), 32'd1);
    step();
    check("unhold_lu_cnt", 32'(bubble_cnt), 32'd2);
    check("unhold_lu_valid", 32'(ex_valid), 32'd0);

    // reset dropped while a load-use stall is active
    set_id(5'd1, 1, 5'd2, 1, 5'd13, 1, 1, 32'h20C);
    step();
    set_id(5'd13, 1, 5'd2, 1, 5'd14, 1, 0, 32'h210);
    #1 check("pre_rst_stall", 32'(stall_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ex_valid", 32'(ex_valid), 32'd0);
    check("arst_ex_pc", ex_pc, 32'd0);
    check("arst_ex_rd", 32'(ex_rd), 32'd0);
    check("arst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("arst_stall", 32'(stall_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
